// File: rtl/rope_pkg.sv
// rope_pkg: shared FSM states, screen geometry and fixed-point helpers for the rope solver
package rope_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ANCHOR, S_INTEGRATE, S_RELAX, S_PUBLISH} state_e;
  typedef logic signed [63:0] wide_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  function automatic wide_t to_fix(input int pix, input int frac);
    return wide_t'(pix) <<< frac;
  endfunction
  function automatic logic [9:0] to_pix(input wide_t p, input int frac);
    return 10'(p >>> frac);
  endfunction
  function automatic wide_t clamp(input wide_t v, input wide_t hi);
    return v < wide_t'(0) ? wide_t'(0) : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/rope_node_alu.sv
// rope_node_alu: one-axis Verlet integrate / Gauss-Seidel relax datapath for a single node
module rope_node_alu
  import rope_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DAMP_SHIFT = 5,
  parameter int K_SHIFT = 2,
  parameter logic signed [WIDTH-1:0] GRAVITY = 32'sh0000_0400
) (
  input  logic                    relax,
  input  logic                    last_free,
  input  logic                    grav_en,
  input  logic signed [WIDTH-1:0] pos,
  input  logic signed [WIDTH-1:0] prv,
  input  logic signed [WIDTH-1:0] nb_prev,
  input  logic signed [WIDTH-1:0] nb_next,
  input  logic signed [WIDTH-1:0] limit,
  output logic signed [WIDTH-1:0] new_pos,
  output logic signed [WIDTH-1:0] new_prv
);
  logic signed [WIDTH+1:0] p, v, g, integ, lap, rel;
  // two guard bits keep the sums exact before truncation or clamping
  always_comb begin
    p = (WIDTH+2)'(pos);
    v = p - (WIDTH+2)'(prv);
    g = grav_en ? (WIDTH+2)'(GRAVITY) : '0;
    integ = p + v - (v >>> DAMP_SHIFT) + g;
    lap = last_free ? (WIDTH+2)'(nb_prev) - p : (WIDTH+2)'(nb_prev) + (WIDTH+2)'(nb_next) - (p <<< 1);
    rel = p + (lap >>> K_SHIFT);
    new_pos = relax ? WIDTH'(clamp(wide_t'(rel), wide_t'(limit))) : WIDTH'(integ);
    new_prv = relax ? prv : pos;
  end
endmodule

// File: rtl/rope_solver.sv
// rope_solver: time-multiplexed rope physics engine with mouse anchor and packed pixel outputs
module rope_solver
  import rope_pkg::*;
#(
  parameter int NODES = 20,
  parameter int WIDTH = 32,
  parameter int FRAC = 12,
  parameter int ITERS = 4,
  parameter logic signed [WIDTH-1:0] GRAVITY = 32'sh0000_0400,
  parameter int DAMP_SHIFT = 5,
  parameter int K_SHIFT = 2,
  parameter int INIT_X = 320,
  parameter int SPACING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  pin_last,
  input  logic [9:0]            in_mouse_x,
  input  logic [9:0]            in_mouse_y,
  output logic                  busy,
  output logic                  done,
  output logic [NODES*10-1:0]   nodes_x,
  output logic [NODES*10-1:0]   nodes_y
);
  localparam int IW = $clog2(NODES + 1);
  localparam int PW = ITERS > 1 ? $clog2(ITERS) : 1;
  localparam logic signed [WIDTH-1:0] LIM_X = WIDTH'(to_fix(SCREEN_W - 1, FRAC));
  localparam logic signed [WIDTH-1:0] LIM_Y = WIDTH'(to_fix(SCREEN_H - 1, FRAC));

  function automatic logic signed [WIDTH-1:0] fix(input int pix);
    return WIDTH'(to_fix(pix, FRAC));
  endfunction

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_prev, idx_next;
  logic [PW-1:0] pass_q, pass_d;
  logic pin_q, pin_d, done_q, done_d, last, skip, relax;
  logic signed [WIDTH-1:0] pos_x_q [NODES], pos_x_d [NODES], pos_y_q [NODES], pos_y_d [NODES];
  logic signed [WIDTH-1:0] prv_x_q [NODES], prv_x_d [NODES], prv_y_q [NODES], prv_y_d [NODES];
  logic signed [WIDTH-1:0] ax_pos, ax_prv, ay_pos, ay_prv;
  logic [NODES*10-1:0] nx_q, nx_d, ny_q, ny_d;

  assign last = idx_q == IW'(NODES - 1);
  assign skip = last & pin_q;
  assign relax = state_q == S_RELAX;
  assign idx_prev = idx_q - IW'(1);
  assign idx_next = last ? idx_q : idx_q + IW'(1);
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign nodes_x = nx_q;
  assign nodes_y = ny_q;

  rope_node_alu #(.WIDTH(WIDTH), .DAMP_SHIFT(DAMP_SHIFT), .K_SHIFT(K_SHIFT), .GRAVITY(GRAVITY)) u_alu_x (
    .relax(relax), .last_free(last), .grav_en(1'b0),
    .pos(pos_x_q[idx_q]), .prv(prv_x_q[idx_q]), .nb_prev(pos_x_q[idx_prev]), .nb_next(pos_x_q[idx_next]),
    .limit(LIM_X), .new_pos(ax_pos), .new_prv(ax_prv)
  );

  rope_node_alu #(.WIDTH(WIDTH), .DAMP_SHIFT(DAMP_SHIFT), .K_SHIFT(K_SHIFT), .GRAVITY(GRAVITY)) u_alu_y (
    .relax(relax), .last_free(last), .grav_en(1'b1),
    .pos(pos_y_q[idx_q]), .prv(prv_y_q[idx_q]), .nb_prev(pos_y_q[idx_prev]), .nb_next(pos_y_q[idx_next]),
    .limit(LIM_Y), .new_pos(ay_pos), .new_prv(ay_prv)
  );

  // sequencer: anchor, integrate each node, relax ITERS passes, then publish pixels
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pass_d = pass_q;
    pin_d = pin_q;
    done_d = 1'b0;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    prv_x_d = prv_x_q;
    prv_y_d = prv_y_q;
    nx_d = nx_q;
    ny_d = ny_q;
    case (state_q)
      S_IDLE: state_d = step ? S_ANCHOR : S_IDLE;
      S_ANCHOR: begin
        pos_x_d[0] = fix(int'(in_mouse_x));
        prv_x_d[0] = fix(int'(in_mouse_x));
        pos_y_d[0] = fix(int'(in_mouse_y));
        prv_y_d[0] = fix(int'(in_mouse_y));
        pin_d = pin_last;
        idx_d = IW'(1);
        state_d = S_INTEGRATE;
      end
      S_INTEGRATE: begin
        pos_x_d[idx_q] = skip ? pos_x_q[idx_q] : ax_pos;
        pos_y_d[idx_q] = skip ? pos_y_q[idx_q] : ay_pos;
        prv_x_d[idx_q] = ax_prv;
        prv_y_d[idx_q] = ay_prv;
        idx_d = last ? IW'(1) : idx_q + IW'(1);
        pass_d = '0;
        state_d = last ? S_RELAX : S_INTEGRATE;
      end
      S_RELAX: begin
        pos_x_d[idx_q] = skip ? pos_x_q[idx_q] : ax_pos;
        pos_y_d[idx_q] = skip ? pos_y_q[idx_q] : ay_pos;
        idx_d = last ? IW'(1) : idx_q + IW'(1);
        pass_d = last ? pass_q + PW'(1) : pass_q;
        state_d = last && pass_q == PW'(ITERS - 1) ? S_PUBLISH : S_RELAX;
      end
      S_PUBLISH: begin
        for (int i = 0; i < NODES; i++) begin
          nx_d[10*i +: 10] = to_pix(wide_t'(pos_x_q[i]), FRAC);
          ny_d[10*i +: 10] = to_pix(wide_t'(pos_y_q[i]), FRAC);
        end
        done_d = 1'b1;
        state_d = step ? S_ANCHOR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // register file, counters and output registers; reset restores the straight hanging line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q <= IW'(1);
      pass_q <= '0;
      pin_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < NODES; i++) begin
        pos_x_q[i] <= fix(INIT_X);
        prv_x_q[i] <= fix(INIT_X);
        pos_y_q[i] <= fix(SPACING * i);
        prv_y_q[i] <= fix(SPACING * i);
        nx_q[10*i +: 10] <= 10'(INIT_X);
        ny_q[10*i +: 10] <= 10'(SPACING * i);
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pass_q <= pass_d;
      pin_q <= pin_d;
      done_q <= done_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      prv_x_q <= prv_x_d;
      prv_y_q <= prv_y_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
    end
  end
endmodule
